// File: rtl/step_tick_gen_pkg.sv
// Shared types and constants for the stepping tick generator.
// Holds the button debounce state encoding and the mode select values.
package step_tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } dbnc_state_e;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser into the clk domain.
// Both stages clear to 0 on the asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // next values of the two capture stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // capture chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/step_tick_gen.sv
// Turns a slow stepping clock or a bouncy push-button into single-cycle
// out_tick enables on the fast clock, with a running tick count.
module step_tick_gen
  import step_tick_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_clk,
  input  logic             btn_step,
  input  logic             mode,
  input  logic             run_en,
  output logic             out_tick,
  output logic             btn_level,
  output logic [CNT_W-1:0] tick_cnt
);

  localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_ZERO = DB_W'(0);
  localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s_clk, s_btn, s_mode;

  sync_2ff u_sync_clk  (.clk(clk), .rst(rst), .d(in_clk),   .q(s_clk));
  sync_2ff u_sync_btn  (.clk(clk), .rst(rst), .d(btn_step), .q(s_btn));
  sync_2ff u_sync_mode (.clk(clk), .rst(rst), .d(mode),     .q(s_mode));

  dbnc_state_e      state_d, state_q;
  logic [DB_W-1:0]  db_cnt_d, db_cnt_q;
  logic             p_clk_d, p_clk_q;
  logic             mode_d, mode_q;
  logic             edge_d, edge_q;
  logic             armed_d, armed_q;
  logic             btn_level_d, btn_level_q;
  logic             out_tick_d, out_tick_q;
  logic [CNT_W-1:0] tick_cnt_d, tick_cnt_q;
  logic             mode_chg;
  logic             man_tick;
  logic             tick_cond;

  // edge detect, mode tracking and press arming
  always_comb begin
    mode_chg = (s_mode != mode_q);
    mode_d   = s_mode;
    p_clk_d  = s_clk;
    edge_d   = 1'b0;
    armed_d  = armed_q;
    if (!mode_chg && (s_mode == MODE_AUTO)) begin
      edge_d = s_clk & ~p_clk_q;
    end else begin
      edge_d = 1'b0;
    end
    // a button held through reset must be seen released before it can count as a press
    if (!mode_chg && (s_mode == MODE_MANUAL) && !s_btn) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // debounce FSM, idle outside manual mode and on any mode change
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    btn_level_d = btn_level_q;
    man_tick    = 1'b0;
    if (mode_chg || (s_mode == MODE_AUTO)) begin
      state_d     = IDLE;
      db_cnt_d    = DB_ZERO;
      btn_level_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_btn && armed_q) begin
            state_d  = PRESS_WAIT;
            db_cnt_d = DB_ZERO;
          end else begin
            state_d = IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!s_btn) begin
            state_d = IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_d     = HELD;
            btn_level_d = 1'b1;
            man_tick    = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end
        end
        HELD: begin
          if (!s_btn) begin
            state_d  = RELEASE_WAIT;
            db_cnt_d = DB_ZERO;
          end else begin
            state_d = HELD;
          end
        end
        RELEASE_WAIT: begin
          if (s_btn) begin
            state_d = HELD;
          end else if (db_cnt_q == DB_LAST) begin
            state_d     = IDLE;
            btn_level_d = 1'b0;
          end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end
        end
        default: begin
          state_d     = IDLE;
          db_cnt_d    = DB_ZERO;
          btn_level_d = 1'b0;
        end
      endcase
    end
  end

  // tick selection, gating and counting
  always_comb begin
    tick_cond  = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (mode_chg) begin
      tick_cond = 1'b0;
    end else if (s_mode == MODE_AUTO) begin
      tick_cond = edge_q;
    end else begin
      tick_cond = man_tick;
    end
    out_tick_d = tick_cond & run_en;
    if (out_tick_d) begin
      tick_cnt_d = tick_cnt_q + CNT_ONE;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= DB_ZERO;
      p_clk_q     <= 1'b0;
      mode_q      <= 1'b0;
      edge_q      <= 1'b0;
      armed_q     <= 1'b0;
      btn_level_q <= 1'b0;
      out_tick_q  <= 1'b0;
      tick_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      p_clk_q     <= p_clk_d;
      mode_q      <= mode_d;
      edge_q      <= edge_d;
      armed_q     <= armed_d;
      btn_level_q <= btn_level_d;
      out_tick_q  <= out_tick_d;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  assign out_tick  = out_tick_q;
  assign btn_level = btn_level_q;
  assign tick_cnt  = tick_cnt_q;

endmodule
